// File: rtl/fma_writeback_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fma_writeback_buffer_if
// Purpose  : Data-cache write-port bundle used by the FMA writeback buffer.
//            The buffer drives the request side (master); the cache returns
//            the ready (slave).
// Signals  : wr_data_out  [WIDTH]       word to write
//            wr_addr_out  [ADDR_WIDTH]  cache word address of wr_data_out
//            wr_valid_out               write request
//            wr_ready_in                cache accepts when high with valid
// Revision : 1.0 - initial release
// ============================================================================
interface fma_writeback_buffer_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [WIDTH-1:0]      wr_data_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic                  wr_valid_out;
  logic                  wr_ready_in;

  modport master (
    output wr_data_out,
    output wr_addr_out,
    output wr_valid_out,
    input  wr_ready_in
  );

  modport slave (
    input  wr_data_out,
    input  wr_addr_out,
    input  wr_valid_out,
    output wr_ready_in
  );
endinterface
`default_nettype wire

// File: rtl/fma_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fma_writeback_buffer
// Purpose  : Captures one parallel result vector from FMA_COUNT FMA lanes in
//            a single cycle and drains it, lane 0 first, to the data-cache
//            write port over a valid/ready handshake.
// Ports    : clk_in        clock (rising edge)
//            rst_in        asynchronous active-low reset
//            fma_out_in    per-lane results, sampled with fma_valid_in
//            fma_valid_in  1-cycle strobe, all lanes valid
//            base_addr_in  cache address of lane 0, sampled with the strobe
//            lane_mask_in  per-lane write enable (mask build only)
//            wr_bus        cache write port (master side)
//            ready_out     high in IDLE, a new vector may be strobed
//            done_out      1-cycle pulse after the last write is accepted
//            overflow_out  sticky: a vector was strobed while busy (dropped)
// Config   : FMA_WB_MASK_EN - when defined, lanes with lane_mask_in[i]=0 are
//            skipped; when undefined, lane_mask_in is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module fma_writeback_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic                  clk_in,
  input  wire logic                  rst_in,
  input  wire logic [WIDTH-1:0]      fma_out_in [FMA_COUNT],
  input  wire logic                  fma_valid_in,
  input  wire logic [ADDR_WIDTH-1:0] base_addr_in,
  input  wire logic [FMA_COUNT-1:0]  lane_mask_in,
  fma_writeback_buffer_if.master     wr_bus,
  output logic                       ready_out,
  output logic                       done_out,
  output logic                       overflow_out
);

  localparam int IDX_W = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      lane_q [FMA_COUNT];
  logic [WIDTH-1:0]      lane_d [FMA_COUNT];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [FMA_COUNT-1:0]  mask_q, mask_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic [FMA_COUNT-1:0]  eff_mask;
  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;

`ifdef FMA_WB_MASK_EN
  assign eff_mask = lane_mask_in;
`else
  logic unused_mask;
  assign eff_mask    = '1;
  assign unused_mask = ^lane_mask_in;
`endif

  // Lowest enabled lane of the incoming vector, and lowest enabled lane of
  // the captured vector above the one currently being presented. Scanning
  // downwards lets the last hit be the lowest index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = FMA_COUNT - 1; i >= 0; i--) begin
      if (eff_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    base_d     = base_q;
    mask_d     = mask_q;
    wr_valid_d = wr_valid_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    // A strobe outside IDLE is dropped; the in-flight vector is untouched.
    if (fma_valid_in && (state_q != S_IDLE)) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (fma_valid_in) begin
          lane_d = fma_out_in;
          base_d = base_addr_in;
          mask_d = eff_mask;
          if (first_found) begin
            idx_d      = first_idx;
            wr_valid_d = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            // Nothing to write: go straight to the completion pulse.
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (wr_valid_q && wr_bus.wr_ready_in) begin
          if (next_found) begin
            idx_d = next_idx;
          end else begin
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < FMA_COUNT; i++) begin
        lane_q[i] <= '0;
      end
      idx_q      <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Data and address follow the registered lane index, so they stay stable
  // while the cache stalls, and read as zero straight out of reset.
  assign wr_bus.wr_data_out  = lane_q[idx_q];
  assign wr_bus.wr_addr_out  = base_q + ADDR_WIDTH'(idx_q);
  assign wr_bus.wr_valid_out = wr_valid_q;
  assign ready_out           = (state_q == S_IDLE);
  assign done_out            = done_q;
  assign overflow_out        = overflow_q;

endmodule
`default_nettype wire
